// File: rtl/aibnd_rxanlg_mc.sv
// aibnd_rxanlg_mc: receive-side analog macro controller.
//
// Sequences the receive path through OFF -> CLK_ON -> DATA_ON. The clock path must
// settle for SETTLE_CYC cycles before a data-enable request is honoured. Each pad bit
// goes through a 2-flop synchroniser. The synchronised data feeds two outputs:
//   - odat: a registered sync path, gated by the next state being DATA_ON.
//   - odat_async: an async path, optionally glitch-filtered, gated by odat_on.
//
// Optional feature: define AIBND_RXANLG_MC_GLITCH_FILT_EN to build the per-channel
// glitch filter. Without it, odat_async is the synchroniser output gated by odat_on.
//
// Ports:
//   iclk       in   receive clock; all state updates on its rising edge
//   irst       in   asynchronous active-high reset
//   iopad      in   [NCH] pad data, asynchronous to iclk
//   clk_en     in   clock-path enable request
//   data_en    in   data-path enable request
//   odat       out  [NCH] synchronised, gated data
//   odat_async out  [NCH] filtered (or raw synchronised), gated data
//   oclk_on    out  clock path enabled (CLK_ON or DATA_ON)
//   odat_on    out  data path enabled (DATA_ON)
//   ostate     out  [2] FSM state: OFF=0, CLK_ON=1, DATA_ON=2
module aibnd_rxanlg_mc #(
  parameter int unsigned NCH        = 8,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned FILT_CYC   = 4
) (
  input  logic           iclk,
  input  logic           irst,
  input  logic [NCH-1:0] iopad,
  input  logic           clk_en,
  input  logic           data_en,
  output logic [NCH-1:0] odat,
  output logic [NCH-1:0] odat_async,
  output logic           oclk_on,
  output logic           odat_on,
  output logic [1:0]     ostate
);

  // Elaboration-time parameter legality checks.
  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("NCH out of range 1..32");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("SETTLE_CYC out of range 1..255");
  end
  if (FILT_CYC < 2 || FILT_CYC > 255) begin : g_bad_filt
    $error("FILT_CYC out of range 2..255");
  end

  typedef enum logic [1:0] {
    StOff    = 2'd0,
    StClkOn  = 2'd1,
    StDataOn = 2'd2
  } state_e;

  localparam logic [7:0] SettleMax = 8'(SETTLE_CYC);

  state_e         state_q, state_d;
  logic [7:0]     settle_q, settle_d;
  logic           oclk_on_q, odat_on_q;
  logic [NCH-1:0] sync1_q, sync2_q;
  logic [NCH-1:0] odat_q, odat_d;
  logic           settled;

  assign settled = (settle_q == SettleMax);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      StOff: begin
        if (clk_en) begin
          state_d  = StClkOn;
          settle_d = '0;
        end
      end
      StClkOn: begin
        if (!settled) settle_d = settle_q + 8'd1;
        if (!clk_en) begin
          state_d  = StOff;
          settle_d = '0;
        end else if (data_en && settled) begin
          state_d = StDataOn;
        end
      end
      StDataOn: begin
        if (!clk_en) begin
          state_d  = StOff;
          settle_d = '0;
        end else if (!data_en) begin
          // Counter is kept, so re-entry to DATA_ON needs no second settle.
          state_d = StClkOn;
        end
      end
      default: begin
        state_d  = StOff;
        settle_d = '0;
      end
    endcase
  end

  // Gate on the next state so odat clears on the very edge that leaves DATA_ON.
  always_comb begin
    odat_d = (state_d == StDataOn) ? sync2_q : '0;
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q   <= StOff;
      settle_q  <= '0;
      oclk_on_q <= 1'b0;
      odat_on_q <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      odat_q    <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      // Status flags are dedicated flops so they never glitch on state decode.
      oclk_on_q <= (state_d != StOff);
      odat_on_q <= (state_d == StDataOn);
      sync1_q   <= iopad;
      sync2_q   <= sync1_q;
      odat_q    <= odat_d;
    end
  end

`ifdef AIBND_RXANLG_MC_GLITCH_FILT_EN
  localparam int unsigned FcntW   = $clog2(FILT_CYC);
  localparam logic [FcntW-1:0] FcntMax = FcntW'(FILT_CYC - 1);

  logic [NCH-1:0]            filt_q, filt_d;
  logic [NCH-1:0][FcntW-1:0] fcnt_q, fcnt_d;

  // A channel's filtered state toggles only after sync2 has disagreed with it for
  // FILT_CYC consecutive cycles; any agreement restarts the count.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FcntMax) begin
        filt_d[i] = ~filt_q[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      filt_q <= '0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign odat_async = filt_q & {NCH{odat_on_q}};
`else
  assign odat_async = sync2_q & {NCH{odat_on_q}};
`endif

  assign odat    = odat_q;
  assign oclk_on = oclk_on_q;
  assign odat_on = odat_on_q;
  assign ostate  = state_q;

endmodule

// File: doc/aibnd_rxanlg_mc.md
AIBND_RXANLG_MC -- requirements
Module: aibnd_rxanlg_mc

Interface
REQ-001 SHALL have parameter NCH, default 8, receive channel count (legal 1..32).
REQ-002 SHALL have parameter SETTLE_CYC, default 16, clock-path settle cycles before data enable is honoured (legal 1..255).
REQ-003 SHALL have parameter FILT_CYC, default 4, async-path glitch filter stability length in cycles (legal 2..255).
REQ-004 SHALL have port iclk  input  1  single receive clock; all state updates on its rising edge.
REQ-005 SHALL have port irst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port iopad  input  NCH  per-channel pad data, asynchronous to iclk.
REQ-007 SHALL have port clk_en  input  1  clock-path enable request.
REQ-008 SHALL have port data_en  input  1  data-path enable request.
REQ-009 SHALL have port odat  output  NCH  synchronised, gated sync data.
REQ-010 SHALL have port odat_async  output  NCH  glitch-filtered, gated async data.
REQ-011 SHALL have port oclk_on  output  1  clock path enabled (state CLK_ON or DATA_ON).
REQ-012 SHALL have port odat_on  output  1  data path enabled (state DATA_ON).
REQ-013 SHALL have port ostate  output  2  FSM state: OFF=0, CLK_ON=1, DATA_ON=2; 3 never produced.

Function
REQ-014 SHALL implement a 3-state enable FSM: OFF, CLK_ON, DATA_ON.
REQ-015 SHALL go OFF->CLK_ON on the edge sampling clk_en=1; settle counter loads 0.
REQ-016 SHALL increment the settle counter each CLK_ON cycle, saturating at SETTLE_CYC; settled = (counter==SETTLE_CYC).
REQ-017 SHALL go CLK_ON->DATA_ON on the edge sampling clk_en=1, data_en=1 and settled=1; data_en=1 while unsettled waits in CLK_ON.
REQ-018 SHALL go DATA_ON->CLK_ON on the edge sampling data_en=0 with clk_en=1; settle counter kept (no re-settle).
REQ-019 SHALL go to OFF from any state on the edge sampling clk_en=0, overriding data_en; settle counter clears to 0.
REQ-020 SHALL derive oclk_on, odat_on, ostate directly from FSM state registers (glitch-free, no combinational input paths).
REQ-021 SHALL pass each iopad bit through a 2-flop synchroniser (sync1, sync2), always clocked regardless of state.
REQ-022 SHALL register odat[i] = sync2[i] when next state is DATA_ON, else 0; iopad edge to odat latency exactly 3 iclk edges while in DATA_ON.
REQ-023 SHALL zero odat on the same edge the FSM leaves DATA_ON.
REQ-024 SHALL give each channel an independent filter: state bit filt[i] and counter fcnt[i] (width ceil(log2(FILT_CYC))).
REQ-025 SHALL clear fcnt[i] when sync2[i]==filt[i]; otherwise increment; when fcnt[i] reaches FILT_CYC-1 while sync2[i]!=filt[i], filt[i] toggles and fcnt[i] clears.
REQ-026 SHALL reject any sync2 pulse shorter than FILT_CYC cycles; a level held FILT_CYC cycles propagates.
REQ-027 SHALL drive odat_async[i] = filt[i] AND odat_on; filter keeps running in all states.
REQ-028 SHALL never permit odat or odat_async nonzero unless odat_on=1.

Reset
REQ-029 SHALL, on irst=1, asynchronously force FSM OFF, settle counter 0, sync1/sync2 0, filt 0, fcnt 0, odat 0, odat_async 0, oclk_on 0, odat_on 0, ostate 0.
REQ-030 SHALL hold reset values while irst=1; first transition evaluated on first rising iclk after irst deasserts.
REQ-031 SHALL abort any in-progress settle or filter count on mid-operation reset; no partial state survives.

Configuration
REQ-032 SHALL compile the glitch filter only when macro AIBND_RXANLG_MC_GLITCH_FILT_EN is defined (REQ-024..026 as written).
REQ-033 SHALL, without AIBND_RXANLG_MC_GLITCH_FILT_EN, omit filt/fcnt and drive odat_async[i] = sync2[i] AND odat_on (2-edge latency, no pulse rejection); all other behaviour unchanged.

Verification
REQ-034 SHALL cover: irst pulse mid-DATA_ON with iopad=8'hFF -> all outputs 0 asynchronously, ostate=0 after release until clk_en sampled.
REQ-035 SHALL cover: clk_en=1, data_en=1 from cycle 0, SETTLE_CYC=16 -> ostate 1 after edge 1, ostate 2 after edge 18, never earlier.
REQ-036 SHALL cover: DATA_ON, iopad[3] 0->1 -> odat[3]=1 after exactly 3 edges; clk_en dropped -> odat=0 and ostate=0 next edge.
REQ-037 SHALL cover: filter on, FILT_CYC=4, 3-cycle pulse on iopad[0] -> odat_async[0] stays 0; 4-cycle level -> odat_async[0]=1.
REQ-038 SHALL cover: DATA_ON->CLK_ON via data_en=0 then data_en=1 -> DATA_ON re-entered after 1 edge (no re-settle).
REQ-039 SHALL cover: macro undefined, 1-cycle pulse in DATA_ON -> odat_async shows 1-cycle pulse 2 edges later.
